// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, instruction fields.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_sequencer_pkg;

   // Opcodes 0-7 write R[ra]; 8-13 are compares that update the flag pair.
   localparam logic [5:0] OP_ADD    = 6'd0;
   localparam logic [5:0] OP_SUB    = 6'd1;
   localparam logic [5:0] OP_AND    = 6'd2;
   localparam logic [5:0] OP_OR     = 6'd3;
   localparam logic [5:0] OP_XOR    = 6'd4;
   localparam logic [5:0] OP_LDI    = 6'd5;
   localparam logic [5:0] OP_SHL    = 6'd6;
   localparam logic [5:0] OP_SHR    = 6'd7;
   localparam logic [5:0] OP_CMPEQ  = 6'd8;
   localparam logic [5:0] OP_CMPNE  = 6'd9;
   localparam logic [5:0] OP_CMPLT  = 6'd10;
   localparam logic [5:0] OP_CMPGE  = 6'd11;
   localparam logic [5:0] OP_CMPLTU = 6'd12;
   localparam logic [5:0] OP_CMPGEU = 6'd13;
   localparam logic [5:0] OP_JMP    = 6'd14;
   localparam logic [5:0] OP_JMPF   = 6'd15;
   localparam logic [5:0] OP_HALT   = 6'd63;

   // Instruction word field positions.
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RA_MSB  = 25;
   localparam int RA_LSB  = 22;
   localparam int RB_MSB  = 21;
   localparam int RB_LSB  = 18;
   localparam int HL_BIT  = 17;
   localparam int VAL_MSB = 15;
   localparam int VAL_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_WRITEBACK,
      ST_HALT
   } state_t;

   function automatic logic op_writes_reg(input logic [5:0] op);
      return op <= OP_SHR;
   endfunction

   function automatic logic op_is_compare(input logic [5:0] op);
      return (op >= OP_CMPEQ) && (op <= OP_CMPGEU);
   endfunction

   function automatic logic op_is_illegal(input logic [5:0] op);
      return (op > OP_JMPF) && (op < OP_HALT);
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of instruction-fetch, ALU and status signals between the sequencer and its environment.
// Latency: n/a (wiring only).
// Backpressure: fetch is held by withholding imem_ack; ALU side has none.
// master = sequencer (drives imem_req/addr, alu_* operands, status); slave = memory + ALU.
interface alu_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;

   logic [5:0]  alu_instr;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_reg8;
   logic [15:0] alu_value;
   logic        alu_highlow;
   logic        alu_f1;
   logic        alu_f2;

   logic [31:0] alu_c;
   logic [31:0] alu_naddr;
   logic        alu_addrch;
   logic        alu_f3;

   logic        halted;
   logic        illegal;
   logic        timeout;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_data,
      output alu_instr, alu_a, alu_b, alu_reg8, alu_value, alu_highlow, alu_f1, alu_f2,
      input  alu_c, alu_naddr, alu_addrch, alu_f3,
      output halted, illegal, timeout
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_data,
      input  alu_instr, alu_a, alu_b, alu_reg8, alu_value, alu_highlow, alu_f1, alu_f2,
      output alu_c, alu_naddr, alu_addrch, alu_f3,
      input  halted, illegal, timeout
   );
endinterface

// File: rtl/seq_regfile.sv
// 16x32 register file: two combinational read ports, one synchronous write port, R[8] tap.
// Latency: reads 0 cycles, write visible after the clock edge.
// Backpressure: none.
// Ports: clock, reset_n (async clear), raddr_a/rdata_a, raddr_b/rdata_b, we/waddr/wdata, reg8.
module seq_regfile (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  raddr_a,
   output logic [31:0] rdata_a,
   input  logic [3:0]  raddr_b,
   output logic [31:0] rdata_b,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  logic [31:0] wdata,
   output logic [31:0] reg8
);
   logic [31:0] regs [16];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];
   assign reg8    = regs[8];
endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving an external ALU from a 16-entry register file.
// Latency: 4 cycles per instruction with zero-wait fetch; each withheld imem_ack adds one cycle.
// Backpressure: FETCH holds imem_req/imem_addr until imem_ack; aborts to HALT after WAIT_LIMIT cycles.
// Ports: clock, reset_n (async active-low), bus (alu_sequencer_if.master: imem_*, alu_*, halted/illegal/timeout).
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned WAIT_LIMIT = 255
) (
   input logic                clock,
   input logic                reset_n,
   alu_sequencer_if.master    bus
);
   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] wait_cnt;

   // Fields of the fetched word, captured on imem_ack.
   logic [5:0]  ir_op;
   logic [3:0]  ir_ra;
   logic [3:0]  ir_rb;
   logic        ir_hl;
   logic [15:0] ir_val;

   // ALU results sampled at the end of EXECUTE; WRITEBACK only uses these.
   logic [31:0] ex_c;
   logic [31:0] ex_naddr;
   logic        ex_addrch;
   logic        ex_f3;

   logic [31:0] rd_a;
   logic [31:0] rd_b;
   logic [31:0] rd_8;
   logic        rf_we;

   seq_regfile u_regfile (
      .clock   (clock),
      .reset_n (reset_n),
      .raddr_a (ir_ra),
      .rdata_a (rd_a),
      .raddr_b (ir_rb),
      .rdata_b (rd_b),
      .we      (rf_we),
      .waddr   (ir_ra),
      .wdata   (ex_c),
      .reg8    (rd_8)
   );

   assign rf_we = (state == ST_WRITEBACK) && op_writes_reg(ir_op);

   // Illegal opcodes always fall through; JMP ignores the ALU's taken bit.
   always_comb begin
      pc_next = pc + 32'd4;
      if (ir_op == OP_JMP) begin
         pc_next = ex_naddr;
      end else if (!op_is_illegal(ir_op) && ex_addrch) begin
         pc_next = ex_naddr;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         pc              <= RESET_PC;
         wait_cnt        <= '0;
         ir_op           <= '0;
         ir_ra           <= '0;
         ir_rb           <= '0;
         ir_hl           <= 1'b0;
         ir_val          <= '0;
         ex_c            <= '0;
         ex_naddr        <= '0;
         ex_addrch       <= 1'b0;
         ex_f3           <= 1'b0;
         bus.imem_req    <= 1'b0;
         bus.imem_addr   <= '0;
         bus.alu_instr   <= '0;
         bus.alu_a       <= '0;
         bus.alu_b       <= '0;
         bus.alu_reg8    <= '0;
         bus.alu_value   <= '0;
         bus.alu_highlow <= 1'b0;
         bus.alu_f1      <= 1'b0;
         bus.alu_f2      <= 1'b0;
         bus.halted      <= 1'b0;
         bus.illegal     <= 1'b0;
         bus.timeout     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state         <= ST_FETCH;
               bus.imem_req  <= 1'b1;
               bus.imem_addr <= pc;
               wait_cnt      <= '0;
            end
            ST_FETCH: begin
               // An ack in the last allowed cycle still wins over the abort.
               if (bus.imem_ack) begin
                  ir_op        <= bus.imem_data[OP_MSB:OP_LSB];
                  ir_ra        <= bus.imem_data[RA_MSB:RA_LSB];
                  ir_rb        <= bus.imem_data[RB_MSB:RB_LSB];
                  ir_hl        <= bus.imem_data[HL_BIT];
                  ir_val       <= bus.imem_data[VAL_MSB:VAL_LSB];
                  bus.imem_req <= 1'b0;
                  state        <= ST_DECODE;
               end else if (wait_cnt == WAIT_LIMIT - 32'd1) begin
                  bus.timeout  <= 1'b1;
                  bus.halted   <= 1'b1;
                  bus.imem_req <= 1'b0;
                  state        <= ST_HALT;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            ST_DECODE: begin
               bus.alu_instr   <= ir_op;
               bus.alu_a       <= rd_a;
               bus.alu_b       <= rd_b;
               bus.alu_reg8    <= rd_8;
               bus.alu_value   <= ir_val;
               bus.alu_highlow <= ir_hl;
               if (ir_op == OP_HALT) begin
                  bus.halted <= 1'b1;
                  state      <= ST_HALT;
               end else begin
                  state <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               ex_c      <= bus.alu_c;
               ex_naddr  <= bus.alu_naddr;
               ex_addrch <= bus.alu_addrch;
               ex_f3     <= bus.alu_f3;
               state     <= ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
               // Register write happens in the regfile on this same edge via rf_we.
               if (op_is_compare(ir_op)) begin
                  bus.alu_f2 <= bus.alu_f1;
                  bus.alu_f1 <= ex_f3;
               end
               if (op_is_illegal(ir_op)) begin
                  bus.illegal <= 1'b1;
               end
               pc            <= pc_next;
               bus.imem_addr <= pc_next;
               bus.imem_req  <= 1'b1;
               wait_cnt      <= '0;
               state         <= ST_FETCH;
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer against a behavioural instruction-level model.
// Latency: n/a.
// Backpressure: the bench plays memory (variable ack delay) and ALU (arbitrary results).
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam int          WL  = 12;

   logic clock;
   logic reset_n;
   alu_sequencer_if bus ();

   alu_sequencer #(.RESET_PC(RPC), .WAIT_LIMIT(WL)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Architectural model: registers, pc, flags, sticky illegal.
   logic [31:0] m_r [16];
   logic [31:0] m_pc;
   logic        m_f1;
   logic        m_f2;
   logic        m_illegal;

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                      input logic hl, input logic [15:0] val);
      return {op, ra, rb, hl, 1'($urandom_range(0, 1)), val};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = '0;
      m_pc      = RPC;
      m_f1      = 1'b0;
      m_f2      = 1'b0;
      m_illegal = 1'b0;
   endtask

   task automatic drive_idle();
      bus.imem_ack   = 1'b0;
      bus.imem_data  = '0;
      bus.alu_c      = '0;
      bus.alu_naddr  = '0;
      bus.alu_addrch = 1'b0;
      bus.alu_f3     = 1'b0;
   endtask

   // Reset, release on a falling edge, and leave the bench at the first FETCH cycle.
   task automatic do_reset();
      reset_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      @(negedge clock);
   endtask

   // Runs one instruction through the DUT from a FETCH cycle; dly = cycles ack is withheld.
   task automatic run_instr(input logic [31:0] w, input int dly, input logic [31:0] c,
                            input logic ach, input logic [31:0] na, input logic f3);
      logic [5:0]  op;
      logic [3:0]  ra;
      logic [3:0]  rb;
      int          guard;
      op = w[31:26];
      ra = w[25:22];
      rb = w[21:18];
      guard = 0;
      while (bus.imem_req !== 1'b1 && guard < 10) begin
         @(negedge clock);
         guard++;
      end
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
         n_bad++;
         $display("FAIL fetch_start: req=%b addr=%h, required req=1 addr=%h", bus.imem_req, bus.imem_addr, m_pc);
      end
      bus.imem_ack = 1'b0;
      for (int k = 0; k < dly; k++) begin
         @(negedge clock);
         n_cmp++;
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_hold[%0d]: req=%b addr=%h to=%b, required 1 %h 0",
                     k, bus.imem_req, bus.imem_addr, bus.timeout, m_pc);
         end
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = w;
      @(negedge clock);
      // Stray acks outside FETCH must be ignored.
      bus.imem_ack  = 1'($urandom_range(0, 1));
      bus.imem_data = $urandom;
      n_cmp++;
      if (bus.imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL req_after_ack: req=%b, required 0", bus.imem_req);
      end
      @(negedge clock);
      if (op == OP_HALT) begin
         n_cmp++;
         if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_entry: halted=%b req=%b, required 1 0", bus.halted, bus.imem_req);
         end
         bus.imem_ack = 1'b0;
         return;
      end
      n_cmp++;
      if ({bus.imem_req, bus.alu_instr, bus.alu_a, bus.alu_b, bus.alu_reg8} !==
          {1'b0, op, m_r[ra], m_r[rb], m_r[8]}) begin
         n_bad++;
         $display("FAIL operands: req=%b instr=%0d a=%h b=%h r8=%h, required 0 %0d %h %h %h",
                  bus.imem_req, bus.alu_instr, bus.alu_a, bus.alu_b, bus.alu_reg8, op, m_r[ra], m_r[rb], m_r[8]);
      end
      n_cmp++;
      if ({bus.alu_value, bus.alu_highlow, bus.alu_f1, bus.alu_f2} !== {w[15:0], w[17], m_f1, m_f2}) begin
         n_bad++;
         $display("FAIL imm_flags: value=%h hl=%b f1=%b f2=%b, required %h %b %b %b",
                  bus.alu_value, bus.alu_highlow, bus.alu_f1, bus.alu_f2, w[15:0], w[17], m_f1, m_f2);
      end
      bus.alu_c      = c;
      bus.alu_addrch = ach;
      bus.alu_naddr  = na;
      bus.alu_f3     = f3;
      @(negedge clock);
      // Results were sampled at the end of EXECUTE; scramble them now.
      bus.alu_c      = $urandom;
      bus.alu_addrch = 1'($urandom_range(0, 1));
      bus.alu_naddr  = $urandom;
      bus.alu_f3     = 1'($urandom_range(0, 1));
      bus.imem_ack   = 1'($urandom_range(0, 1));
      if (op <= 6'd7) begin
         m_r[ra] = c;
      end else if (op <= 6'd13) begin
         m_f2 = m_f1;
         m_f1 = f3;
      end
      if (op == 6'd14)       m_pc = na;
      else if (op >= 6'd16) begin
         m_illegal = 1'b1;
         m_pc      = m_pc + 32'd4;
      end
      else if (ach)          m_pc = na;
      else                   m_pc = m_pc + 32'd4;
      @(negedge clock);
      bus.imem_ack = 1'b0;
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.illegal !== m_illegal) begin
         n_bad++;
         $display("FAIL next_fetch: req=%b addr=%h illegal=%b, required 1 %h %b",
                  bus.imem_req, bus.imem_addr, bus.illegal, m_pc, m_illegal);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({bus.imem_req, bus.imem_addr, bus.alu_instr, bus.alu_a, bus.alu_b, bus.alu_reg8, bus.alu_value,
           bus.alu_highlow, bus.alu_f1, bus.alu_f2, bus.halted, bus.illegal, bus.timeout} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: req=%b addr=%h instr=%h a=%h b=%h halted=%b illegal=%b timeout=%b, required all 0",
                  bus.imem_req, bus.imem_addr, bus.alu_instr, bus.alu_a, bus.alu_b, bus.halted, bus.illegal, bus.timeout);
      end
      reset_n = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if (bus.imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL release_no_edge: req=%b, required 0", bus.imem_req);
      end
      @(negedge clock);
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin
         n_bad++;
         $display("FAIL first_fetch: req=%b addr=%h, required 1 %h", bus.imem_req, bus.imem_addr, RPC);
      end
   endtask

   task automatic test_add();
      run_instr(mk(OP_LDI, 4'd1, 4'd0, 1'b0, 16'd5), 0, 32'd5, 1'b0, 32'h0, 1'b0);
      run_instr(mk(OP_LDI, 4'd2, 4'd0, 1'b0, 16'd7), 0, 32'd7, 1'b0, 32'h0, 1'b0);
      // ADD R1,R2: operands 5 and 7 are checked in EXECUTE, R1=12 on the following read.
      run_instr(mk(OP_ADD, 4'd1, 4'd2, 1'b0, 16'd0), 0, 32'd12, 1'b0, 32'h0, 1'b0);
      run_instr(mk(OP_SUB, 4'd0, 4'd1, 1'b0, 16'd0), 0, 32'd0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_ldi();
      run_instr(mk(OP_LDI, 4'd3, 4'd0, 1'b1, 16'hABCD), 1, 32'hABCD_0000, 1'b0, 32'h0, 1'b0);
      run_instr(mk(OP_OR, 4'd3, 4'd3, 1'b0, 16'd0), 0, 32'hABCD_0000, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_flag_branch();
      run_instr(mk(OP_CMPEQ, 4'd1, 4'd2, 1'b0, 16'd0), 0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
      run_instr(mk(OP_JMPF, 4'd0, 4'd0, 1'b0, 16'd0), 0, 32'h0, 1'b1, 32'h40, 1'b0);
      n_cmp++;
      if (bus.alu_f1 !== 1'b1 || bus.imem_addr !== 32'h40) begin
         n_bad++;
         $display("FAIL cmp_then_jmpf: f1=%b addr=%h, required 1 00000040", bus.alu_f1, bus.imem_addr);
      end
   endtask

   task automatic test_wait();
      run_instr(mk(OP_XOR, 4'd5, 4'd3, 1'b0, 16'd0), 3, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
      run_instr(mk(OP_AND, 4'd6, 4'd5, 1'b0, 16'd0), WL - 1, 32'h0F0F_0F0F, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (bus.timeout !== 1'b0 || bus.halted !== 1'b0) begin
         n_bad++;
         $display("FAIL ack_at_limit: timeout=%b halted=%b, required 0 0", bus.timeout, bus.halted);
      end
   endtask

   task automatic test_align_wrap();
      run_instr(mk(OP_JMP, 4'd0, 4'd0, 1'b0, 16'd0), 0, 32'h0, 1'b0, 32'h0000_0043, 1'b0);
      run_instr(mk(OP_JMP, 4'd0, 4'd0, 1'b0, 16'd0), 0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0);
      run_instr(mk(OP_SHL, 4'd7, 4'd1, 1'b0, 16'd0), 0, 32'h18, 1'b0, 32'h1111_1110, 1'b0);
      n_cmp++;
      if (bus.imem_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL pc_wrap: addr=%h, required 00000000", bus.imem_addr);
      end
   endtask

   task automatic test_random();
      logic [5:0] op;
      for (int n = 0; n < 60; n++) begin
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(16, 62)) : 6'($urandom_range(0, 15));
         run_instr(mk(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      16'($urandom)),
                   $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), $urandom,
                   1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_illegal_halt();
      do_reset();
      run_instr(mk(6'd20, 4'd2, 4'd3, 1'b0, 16'd0), 0, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0);
      n_cmp++;
      if (bus.illegal !== 1'b1 || bus.imem_addr !== RPC + 32'd4) begin
         n_bad++;
         $display("FAIL illegal_op: illegal=%b addr=%h, required 1 %h", bus.illegal, bus.imem_addr, RPC + 32'd4);
      end
      run_instr(mk(OP_HALT, 4'd0, 4'd0, 1'b0, 16'd0), 0, 32'h0, 1'b0, 32'h0, 1'b0);
      bus.imem_ack = 1'b1;
      repeat (5) @(negedge clock);
      n_cmp++;
      if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1 || bus.illegal !== 1'b1) begin
         n_bad++;
         $display("FAIL halt_stays: req=%b halted=%b illegal=%b, required 0 1 1", bus.imem_req, bus.halted, bus.illegal);
      end
      bus.imem_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.imem_ack  = 1'b1;
      bus.imem_data = mk(OP_ADD, 4'd4, 4'd1, 1'b0, 16'd0);
      @(negedge clock);
      bus.imem_ack = 1'b0;
      @(negedge clock);
      // Mid-EXECUTE: ALU offers a result, then reset hits before it can be written.
      bus.alu_c     = 32'hDEAD_0004;
      bus.alu_naddr = 32'h0000_0100;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.imem_req !== 1'b0 || bus.alu_instr !== 6'd0 || bus.imem_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL async_reset: req=%b instr=%h addr=%h, required 0 00 00000000",
                  bus.imem_req, bus.alu_instr, bus.imem_addr);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      drive_idle();
      @(negedge clock);
      // Model says R4 is still zero; the EXECUTE check of this read confirms it.
      run_instr(mk(OP_ADD, 4'd4, 4'd4, 1'b0, 16'd0), 0, 32'h9, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_timeout();
      do_reset();
      bus.imem_ack = 1'b0;
      repeat (WL - 1) @(negedge clock);
      n_cmp++;
      if (bus.timeout !== 1'b0 || bus.imem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL before_timeout: timeout=%b req=%b, required 0 1", bus.timeout, bus.imem_req);
      end
      @(negedge clock);
      n_cmp++;
      if (bus.timeout !== 1'b1 || bus.halted !== 1'b1 || bus.imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout: timeout=%b halted=%b req=%b, required 1 1 0", bus.timeout, bus.halted, bus.imem_req);
      end
      bus.imem_ack = 1'b1;
      repeat (3) @(negedge clock);
      n_cmp++;
      if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1 || bus.timeout !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_sticky: req=%b halted=%b timeout=%b, required 0 1 1",
                  bus.imem_req, bus.halted, bus.timeout);
      end
      bus.imem_ack = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      drive_idle();
      model_reset();
      test_reset();
      test_add();
      test_ldi();
      test_flag_branch();
      test_wait();
      test_align_wrap();
      test_random();
      test_illegal_halt();
      test_reset_mid();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter WAIT_LIMIT, default 255, fetch cycles without ack before the fetch is aborted.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req / imem_addr  output  1 / 32  instruction fetch request and byte address.
REQ-006 imem_ack / imem_data  input  1 / 32  fetch acknowledge and instruction word, valid when imem_ack=1.
REQ-007 alu_instr / alu_a / alu_b / alu_reg8  output  6 / 32 / 32 / 32  ALU opcode, operands, register 8 contents.
REQ-008 alu_value / alu_highlow  output  16 / 1  load immediate and half select.
REQ-009 alu_f1 / alu_f2  output  1 / 1  flag registers presented to the ALU.
REQ-010 alu_c / alu_naddr  input  32 / 32  ALU result and branch target.
REQ-011 alu_addrch / alu_f3  input  1 / 1  branch-taken and compare result from the ALU.
REQ-012 halted / illegal / timeout  output  1 / 1 / 1  halt state; sticky undefined-opcode and fetch-timeout flags.

Function
REQ-013 Word format: [31:26] opcode, [25:22] ra (A source and destination), [21:18] rb (B source), [17] highlow, [16] ignored, [15:0] value.
REQ-014 FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT; IDLE->FETCH on the first clock after reset release.
REQ-015 FETCH: imem_req=1, imem_addr=pc, both stable until imem_ack=1; ack latches imem_data, FSM->DECODE next cycle.
REQ-016 imem_ack outside FETCH is ignored; zero-wait ack gives 4 cycles per instruction.
REQ-017 FETCH with no ack for WAIT_LIMIT cycles: set timeout, drop imem_req, go to HALT.
REQ-018 DECODE: register alu_instr=opcode, alu_a=R[ra], alu_b=R[rb], alu_reg8=R[8], alu_value, alu_highlow; held constant through EXECUTE and WRITEBACK.
REQ-019 EXECUTE: sample alu_c, alu_addrch, alu_naddr, alu_f3 at the end of the cycle.
REQ-020 WRITEBACK, opcodes 0-7: R[ra] <= sampled alu_c.
REQ-021 WRITEBACK, opcodes 8-13: alu_f2 <= alu_f1, alu_f1 <= sampled alu_f3; no register write.
REQ-022 WRITEBACK, every opcode: pc <= sampled alu_naddr if sampled alu_addrch=1, else pc+4 modulo 2^32.
REQ-023 Opcode 14: unconditional jump, target is alu_naddr.
REQ-024 Opcode 15: jump only when the ALU raises alu_addrch.
REQ-025 Opcode 63: FSM->HALT after DECODE with no write, pc unchanged; halted=1; HALT exits only by reset.
REQ-026 Opcodes 16-62: set illegal (sticky), no write, pc+4, continue.
REQ-027 Branch target with bits [1:0]≠0 is used unchanged.
REQ-028 pc=32'hFFFF_FFFC with no branch wraps to 0.

Reset
REQ-029 Reset asserts asynchronously: state=IDLE, pc=RESET_PC, R[0..15]=0, all outputs 0 (imem_req=0 same cycle).
REQ-030 Reset during FETCH, EXECUTE or WRITEBACK abandons the instruction with no register/flag/pc update.
REQ-031 Reset release takes effect on the next clock edge.

Structure
REQ-032 Shared package holds opcode constants (ADD=0 ... JMPF=15, HALT=63), the FSM state enum, and instruction field positions.
REQ-033 Register file is one sub-module, seq_regfile: 16x32, two combinational read ports, one synchronous write port, dedicated R[8] tap.

Verification
REQ-034 R1=5, R2=7, opcode 0 (ra=1, rb=2), model ALU returns 12 -> R1=12 at WRITEBACK, pc 0->4, four cycles with zero-wait ack.
REQ-035 Opcode 5, ra=3, highlow=1, value=16'hABCD, ALU returns 32'hABCD_0000 -> R3=32'hABCD_0000.
REQ-036 Opcode 8 with alu_f3=1, then opcode 15 with alu_addrch=1, alu_naddr=32'h40 -> alu_f1=1, next imem_addr=32'h40.
REQ-037 imem_ack withheld 3 cycles -> imem_req and imem_addr stable 4 cycles; imem_ack withheld WAIT_LIMIT cycles -> timeout=1, halted=1.
REQ-038 Opcode 20 -> illegal=1, pc+4; next word opcode 63 -> halted=1, imem_req stays 0.
REQ-039 reset_n low mid-EXECUTE of an opcode-0 write to R4 -> R4 stays 0, pc=RESET_PC, imem_req=0 before the next edge.
